// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem handshake and IF/ID registers; define FETCH_ALIGN_ERR_EN for a sticky misaligned-fetch err
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallCtrl,
  input  logic        takeBranch_EXMEM,
  input  logic [15:0] branchTarget_EXMEM,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] instr_IFID,
  output logic [15:0] PC2_IFID,
  output logic        halt_IFID,
  output logic        err
);
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_HALTED} state_t;
  state_t state, state_nxt;
  logic [15:0] pc, skid, pc2, new_instr;
  logic new_avail, new_halt, load;
  assign pc2       = pc + 16'd2;
  assign new_avail = (state == S_WAIT && imem_valid) || state == S_HOLD;
  assign new_instr = state == S_HOLD ? skid : imem_rdata;
  assign new_halt  = new_instr[15:11] == HALT_OPC;
  assign load      = new_avail && !stallCtrl && !takeBranch_EXMEM;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_REQ;
    else state <= state_nxt;
  // next state; a redirect with a response still in flight must drain it first
  always_comb begin
    state_nxt = state;
    if (takeBranch_EXMEM)
      state_nxt = (state == S_REQ || ((state == S_WAIT || state == S_DRAIN) && !imem_valid)) ? S_DRAIN : S_REQ;
    else
      unique case (state)
        S_REQ:    state_nxt = S_WAIT;
        S_WAIT:   state_nxt = !imem_valid ? S_WAIT : stallCtrl ? S_HOLD : new_halt ? S_HALTED : S_REQ;
        S_HOLD:   state_nxt = stallCtrl ? S_HOLD : new_halt ? S_HALTED : S_REQ;
        S_DRAIN:  state_nxt = imem_valid ? S_REQ : S_DRAIN;
        S_HALTED: state_nxt = S_HALTED;
        default:  state_nxt = S_REQ;
      endcase
  end
  // memory interface outputs decoded from the registered state
  always_comb begin
    imem_req  = rst && state == S_REQ;
    imem_addr = pc;
  end
  // PC advances on every delivered instruction and jumps on redirect
  always_ff @(posedge clk or negedge rst)
    if (!rst) pc <= RESET_PC;
    else if (takeBranch_EXMEM) pc <= branchTarget_EXMEM;
    else if (load) pc <= pc2;
  // skid buffer holds a response that arrived while decode was stalled
  always_ff @(posedge clk or negedge rst)
    if (!rst) skid <= '0;
    else if (takeBranch_EXMEM) skid <= '0;
    else if (state == S_WAIT && imem_valid && stallCtrl) skid <= imem_rdata;
  // IF/ID register: flush, hold, load, else bubble
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      instr_IFID <= NOP_INSTR;
      PC2_IFID   <= '0;
      halt_IFID  <= 1'b0;
    end else if (takeBranch_EXMEM || (!stallCtrl && !new_avail)) begin
      instr_IFID <= NOP_INSTR;
      halt_IFID  <= 1'b0;
    end else if (load) begin
      instr_IFID <= new_instr;
      PC2_IFID   <= pc2;
      halt_IFID  <= new_halt;
    end
`ifdef FETCH_ALIGN_ERR_EN
  // sticky error on any request to an odd address
  always_ff @(posedge clk or negedge rst)
    if (!rst) err <= 1'b0;
    else if (imem_req && pc[0]) err <= 1'b1;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized run against a transaction-level fetch model
module tb_fetch_stage;
  logic clk = 0, rst = 1, stallCtrl = 0, takeBranch_EXMEM = 0, imem_valid = 0;
  logic [15:0] branchTarget_EXMEM = 0, imem_rdata = 0;
  logic imem_req, halt_IFID, err;
  logic [15:0] imem_addr, instr_IFID, PC2_IFID;
  logic [15:0] mem [256];
  logic [15:0] pend_addr = 0;
  logic exp_err;
  int tests = 0, fails = 0, lat = 1, cnt = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stallCtrl(stallCtrl), .takeBranch_EXMEM(takeBranch_EXMEM),
    .branchTarget_EXMEM(branchTarget_EXMEM), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instr_IFID(instr_IFID),
    .PC2_IFID(PC2_IFID), .halt_IFID(halt_IFID), .err(err)
  );

  always #5 clk = ~clk;

  initial begin : memory
    forever begin
      @(negedge clk);
      imem_valid = 0;
      if (!rst) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            imem_valid = 1;
            imem_rdata = mem[pend_addr[8:1]];
          end
        end
        if (imem_req) begin
          cnt = lat;
          pend_addr = imem_addr;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 0; stallCtrl = 0; takeBranch_EXMEM = 0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1;
    cyc(1);
  endtask

  task automatic test_reset();
    rst = 1;
    @(negedge clk);
    #1 rst = 0;
    #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", imem_req); end
    tests++; if (instr_IFID !== 16'h0800) begin fails++; $display("FAIL reset_instr got %h exp 0800", instr_IFID); end
    tests++; if (PC2_IFID !== 16'h0000) begin fails++; $display("FAIL reset_pc2 got %h exp 0000", PC2_IFID); end
    tests++; if (halt_IFID !== 1'b0) begin fails++; $display("FAIL reset_halt got %b exp 0", halt_IFID); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
    tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr got %h exp 0000", imem_addr); end
  endtask

  task automatic test_basic();
    lat = 1;
    mem[0] = 16'h4000; mem[1] = 16'h4100; mem[2] = 16'h0000;
    do_reset();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin fails++; $display("FAIL basic_first_req got %b/%h exp 1/0000", imem_req, imem_addr); end
    cyc(2);
    tests++; if (instr_IFID !== 16'h4000 || PC2_IFID !== 16'h0002) begin fails++; $display("FAIL basic_i0 got %h/%h exp 4000/0002", instr_IFID, PC2_IFID); end
    cyc(2);
    tests++; if (instr_IFID !== 16'h4100 || PC2_IFID !== 16'h0004) begin fails++; $display("FAIL basic_i1 got %h/%h exp 4100/0004", instr_IFID, PC2_IFID); end
    cyc(2);
    tests++; if (instr_IFID !== 16'h0000 || PC2_IFID !== 16'h0006 || halt_IFID !== 1'b1) begin fails++; $display("FAIL basic_halt got %h/%h/%b exp 0000/0006/1", instr_IFID, PC2_IFID, halt_IFID); end
    cyc(1);
    tests++; if (instr_IFID !== 16'h0800 || halt_IFID !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL basic_after_halt got %h/%b/%b exp 0800/0/0", instr_IFID, halt_IFID, imem_req); end
    cyc(3);
    tests++; if (imem_req !== 1'b0 || imem_addr !== 16'h0006) begin fails++; $display("FAIL basic_halted got %b/%h exp 0/0006", imem_req, imem_addr); end
  endtask

  task automatic test_stall();
    lat = 1;
    mem[0] = 16'h4000; mem[1] = 16'h4100; mem[2] = 16'h4200; mem[3] = 16'h4300;
    mem[8'h20] = 16'h4500; mem[8'h21] = 16'h4600; mem[8'h40] = 16'h4700; mem[8'hFF] = 16'h4000;
    do_reset();
    cyc(2);
    tests++; if (instr_IFID !== 16'h4000) begin fails++; $display("FAIL stall_pre got %h exp 4000", instr_IFID); end
    stallCtrl = 1;
    cyc(1);
    tests++; if (instr_IFID !== 16'h4000) begin fails++; $display("FAIL stall_hold1 got %h exp 4000", instr_IFID); end
    cyc(1);
    tests++; if (instr_IFID !== 16'h4000 || imem_req !== 1'b0) begin fails++; $display("FAIL stall_hold2 got %h/%b exp 4000/0", instr_IFID, imem_req); end
    cyc(1);
    tests++; if (instr_IFID !== 16'h4000 || PC2_IFID !== 16'h0002 || imem_req !== 1'b0) begin fails++; $display("FAIL stall_hold3 got %h/%h/%b exp 4000/0002/0", instr_IFID, PC2_IFID, imem_req); end
    stallCtrl = 0;
    cyc(1);
    tests++; if (instr_IFID !== 16'h4100 || PC2_IFID !== 16'h0004) begin fails++; $display("FAIL stall_skid got %h/%h exp 4100/0004", instr_IFID, PC2_IFID); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin fails++; $display("FAIL stall_next_req got %b/%h exp 1/0004", imem_req, imem_addr); end
  endtask

  task automatic test_branch_drain();
    cyc(1);
    lat = 2;
    cyc(1);
    tests++; if (instr_IFID !== 16'h4200 || imem_req !== 1'b1 || imem_addr !== 16'h0006) begin fails++; $display("FAIL drain_pre got %h/%b/%h exp 4200/1/0006", instr_IFID, imem_req, imem_addr); end
    lat = 1;
    cyc(1);
    takeBranch_EXMEM = 1; branchTarget_EXMEM = 16'h0040;
    cyc(1);
    takeBranch_EXMEM = 0;
    tests++; if (instr_IFID !== 16'h0800 || PC2_IFID !== 16'h0006) begin fails++; $display("FAIL drain_flush got %h/%h exp 0800/0006", instr_IFID, PC2_IFID); end
    tests++; if (imem_req !== 1'b0 || imem_addr !== 16'h0040) begin fails++; $display("FAIL drain_wait got %b/%h exp 0/0040", imem_req, imem_addr); end
    cyc(1);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || instr_IFID !== 16'h0800) begin fails++; $display("FAIL drain_discard got %b/%h/%h exp 1/0040/0800", imem_req, imem_addr, instr_IFID); end
    cyc(2);
    tests++; if (instr_IFID !== 16'h4500 || PC2_IFID !== 16'h0042) begin fails++; $display("FAIL drain_target got %h/%h exp 4500/0042", instr_IFID, PC2_IFID); end
  endtask

  task automatic test_flush_hold();
    stallCtrl = 1;
    cyc(2);
    tests++; if (instr_IFID !== 16'h4500 || imem_req !== 1'b0) begin fails++; $display("FAIL hold_pre got %h/%b exp 4500/0", instr_IFID, imem_req); end
    takeBranch_EXMEM = 1; branchTarget_EXMEM = 16'h0080;
    cyc(1);
    takeBranch_EXMEM = 0; stallCtrl = 0;
    tests++; if (instr_IFID !== 16'h0800 || halt_IFID !== 1'b0 || PC2_IFID !== 16'h0042) begin fails++; $display("FAIL hold_flush got %h/%b/%h exp 0800/0/0042", instr_IFID, halt_IFID, PC2_IFID); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin fails++; $display("FAIL hold_req got %b/%h exp 1/0080", imem_req, imem_addr); end
    cyc(2);
    tests++; if (instr_IFID !== 16'h4700 || PC2_IFID !== 16'h0082) begin fails++; $display("FAIL hold_target got %h/%h exp 4700/0082", instr_IFID, PC2_IFID); end
  endtask

  task automatic test_wrap();
    takeBranch_EXMEM = 1; branchTarget_EXMEM = 16'hFFFE;
    cyc(1);
    takeBranch_EXMEM = 0;
    cyc(1);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE) begin fails++; $display("FAIL wrap_req got %b/%h exp 1/fffe", imem_req, imem_addr); end
    cyc(2);
    tests++; if (instr_IFID !== 16'h4000 || PC2_IFID !== 16'h0000) begin fails++; $display("FAIL wrap_pc2 got %h/%h exp 4000/0000", instr_IFID, PC2_IFID); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin fails++; $display("FAIL wrap_next got %b/%h exp 1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_align();
`ifdef FETCH_ALIGN_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    takeBranch_EXMEM = 1; branchTarget_EXMEM = 16'h0041;
    cyc(1);
    takeBranch_EXMEM = 0;
    cyc(1);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0041 || err !== 1'b0) begin fails++; $display("FAIL align_req got %b/%h/%b exp 1/0041/0", imem_req, imem_addr, err); end
    cyc(1);
    tests++; if (err !== exp_err) begin fails++; $display("FAIL align_err got %b exp %b", err, exp_err); end
    cyc(4);
    tests++; if (err !== exp_err) begin fails++; $display("FAIL align_sticky got %b exp %b", err, exp_err); end
    rst = 0;
    #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL align_clear got %b exp 0", err); end
  endtask

  task automatic test_random();
    logic [15:0] e_pc, e_instr, e_pc2, d, t;
    logic e_halt, want_req, outst, drain, skid, loaded, pend, v, s, b;
    for (int i = 0; i < 256; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 15) == 0) d[15:11] = 5'b00000;
      else if (d[15:11] == 5'b00000 || d == 16'h0800) d[15:11] = 5'b00010;
      mem[i] = d;
    end
    lat = 1;
    do_reset();
    e_pc = 0; e_instr = 16'h0800; e_pc2 = 0; e_halt = 0;
    want_req = 1; outst = 0; drain = 0; skid = 0;
    for (int c = 0; c < 3000; c++) begin
      tests++; if (instr_IFID !== e_instr || PC2_IFID !== e_pc2 || halt_IFID !== e_halt) begin fails++; $display("FAIL rnd_ifid cyc %0d got %h/%h/%b exp %h/%h/%b", c, instr_IFID, PC2_IFID, halt_IFID, e_instr, e_pc2, e_halt); end
      tests++; if (imem_req !== want_req || imem_addr !== e_pc) begin fails++; $display("FAIL rnd_req cyc %0d got %b/%h exp %b/%h", c, imem_req, imem_addr, want_req, e_pc); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL rnd_err cyc %0d got %b exp 0", c, err); end
      v = imem_valid;
      s = $urandom_range(0, 99) < 30;
      b = $urandom_range(0, 99) < 6;
      t = 16'($urandom) & 16'hFFFE;
      lat = $urandom_range(1, 3);
      stallCtrl = s; takeBranch_EXMEM = b; branchTarget_EXMEM = t;
      if (b) begin
        pend = want_req || (outst && !v);
        outst = pend; drain = pend; want_req = !pend; skid = 0;
        e_pc = t; e_instr = 16'h0800; e_halt = 0;
      end else begin
        loaded = 0;
        if (want_req) begin
          outst = 1; want_req = 0;
        end else if (outst && v) begin
          outst = 0;
          if (drain) begin drain = 0; want_req = 1; end
          else if (s) skid = 1;
          else loaded = 1;
        end else if (skid && !s) begin
          skid = 0; loaded = 1;
        end
        if (loaded) begin
          d = mem[e_pc[8:1]];
          e_instr = d; e_pc2 = e_pc + 16'd2; e_halt = d[15:11] == 5'b00000;
          e_pc = e_pc + 16'd2; want_req = !e_halt;
        end else if (!s) begin
          e_instr = 16'h0800; e_halt = 0;
        end
      end
      cyc(1);
    end
    stallCtrl = 0; takeBranch_EXMEM = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_branch_drain();
    test_flush_hold();
    test_wrap();
    test_align();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the PC, drives a single-outstanding instruction-memory handshake, and registers the IF/ID pipeline outputs consumed by decode (instr_IFID, PC2_IFID, halt_IFID).
- Honours the hazard stall from decode and the EX/MEM branch/jump redirect.
- Inserts NOP bubbles when no fetched instruction is available.
- Detects the halt opcode and stops fetching.

Parameters:
- RESET_PC, 16'h0000: PC value loaded at reset.
- NOP_INSTR, 16'h0800: bubble instruction (opcode 00001).
- HALT_OPC, 5'b00000: opcode in instr[15:11] that halts fetch.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- stallCtrl  in  1  decode hazard stall; hold PC and IF/ID.
- takeBranch_EXMEM  in  1  redirect request from EX/MEM.
- branchTarget_EXMEM  in  16  redirect target PC.
- imem_req  out  1  memory request strobe, one cycle per fetch.
- imem_addr  out  16  fetch address (= PC); valid while imem_req=1.
- imem_rdata  in  16  instruction word; valid when imem_valid=1.
- imem_valid  in  1  response strobe, 1 cycle, at least 1 cycle after the accepted request.
- instr_IFID  out  16  IF/ID instruction.
- PC2_IFID  out  16  IF/ID PC+2 of that instruction.
- halt_IFID  out  1  IF/ID instruction is a halt.
- err  out  1  fetch error (see Optional Feature); 0 otherwise.

Behaviour:
- Reset (rst=0, async): PC=RESET_PC, state=REQ, instr_IFID=NOP_INSTR, PC2_IFID=0, halt_IFID=0, err=0, skid buffer empty. imem_req=0 while rst=0. First request is issued in the first cycle after release.
- One request outstanding max. imem_req is registered-state decoded: 1 only in REQ. imem_addr=PC in all states.
- States and transitions:
  - REQ: assert imem_req, then go to WAIT.
  - WAIT: hold until imem_valid. On imem_valid with stallCtrl=0, load IF/ID: instr=imem_rdata, PC2=PC+2, halt=(imem_rdata[15:11]==HALT_OPC). Set PC=PC+2, then go to HALTED if halt, else REQ. On imem_valid with stallCtrl=1, capture imem_rdata into the skid buffer and go to HOLD.
  - HOLD: when stallCtrl=0, load IF/ID from the skid buffer (same rules as WAIT), then go to REQ or HALTED.
  - DRAIN: wait for imem_valid, discard the data, then go to REQ. No IF/ID load.
  - HALTED: imem_req=0; PC frozen. Leave only on redirect.
- IF/ID update priority per cycle:
  1. takeBranch_EXMEM=1: IF/ID <= {NOP_INSTR, PC2 unchanged, halt=0} (flush).
  2. stallCtrl=1: hold all IF/ID values.
  3. New instruction available (WAIT with imem_valid, or HOLD): load it.
  4. Otherwise: insert bubble, instr=NOP_INSTR, halt=0, PC2 unchanged.
- halt_IFID is delivered exactly once. Subsequent cycles carry NOP bubbles unless stalled.
- Redirect (takeBranch_EXMEM=1) overrides stall, in any state:
  - PC <= branchTarget_EXMEM; skid buffer cleared.
  - From REQ, or WAIT without imem_valid in the same cycle: response outstanding, next state DRAIN.
  - From WAIT with imem_valid same cycle, HOLD, DRAIN with imem_valid same cycle, or HALTED: next state REQ.
  - From DRAIN without imem_valid: stay DRAIN.
- PC arithmetic: 16-bit, wraps modulo 2^16 (16'hFFFE+2 = 16'h0000).
- Reset asserted mid-transaction: state returns to REQ; any late imem_valid after reset release, while in REQ, is ignored. Memory must also be reset.

Optional Feature:
- Macro FETCH_ALIGN_ERR_EN.
- Defined: when imem_req=1 and PC[0]=1, err is set on that edge and stays set (sticky) until reset. The fetch still proceeds.
- Undefined: err tied 0, no alignment logic.

Test Plan:
- Release reset with a 1-cycle-latency memory returning 16'h4000, 16'h4100, 16'h0000 at 0x0, 0x2, 0x4 -> IF/ID shows 4000/PC2=0002, then 4100/0004, then 0000/0006 with halt_IFID=1 for one load. Afterwards imem_req stays 0 and IF/ID shows 0800.
- stallCtrl=1 for 3 cycles spanning the imem_valid of 16'h4100 -> IF/ID holds 4000/0002 through the stall. Then 4100/0004 loads the cycle after stall drops, from the skid buffer; no re-fetch of 0x2.
- takeBranch_EXMEM=1, target 16'h0040, in the cycle after a request to 0x6 -> DRAIN discards the 0x6 response, IF/ID=0800, next imem_addr=0040.
- takeBranch_EXMEM and stallCtrl both 1 in HOLD -> flush wins: IF/ID=0800, skid discarded, next request to target.
- Redirect to 16'hFFFE with memory returning 16'h4000 -> PC2_IFID=0000 (wrap); next imem_addr=0000.
- With FETCH_ALIGN_ERR_EN defined, redirect to 16'h0041 -> err=1 after the request edge and remains 1 until rst=0. Without the macro, err stays 0.
